// File: rtl/combination_pkg.sv
// Shared constants and pointer type for the go-back-N replay buffer.
package combination_pkg;

   localparam int WIDTH = 1024;   // data word width
   localparam int DEPTH = 8;      // buffer entries, power of two
   localparam int AW    = 3;      // log2(DEPTH)

   // Pointers carry one extra wrap bit so full and empty can be told apart.
   typedef logic [AW:0] ptr_t;

endpackage : combination_pkg

// File: rtl/combination_replay_mem.sv
// DEPTH x WIDTH storage: one write port, one registered read port with enable.
// Only the read register is reset; the array contents are not.
module combination_replay_mem
   import combination_pkg::*;
#(
   parameter int MW  = WIDTH,
   parameter int MD  = DEPTH,
   parameter int MAW = AW
) (
   input  logic           clk,
   input  logic           srst,
   input  logic           we_i,
   input  logic [MAW-1:0] waddr_i,
   input  logic [MW-1:0]  wdata_i,
   input  logic           re_i,
   input  logic [MAW-1:0] raddr_i,
   output logic [MW-1:0]  rdata_o
);

   logic [MW-1:0] mem_q [MD];
   logic [MW-1:0] rdata_q;

   // Array write port; left unreset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Registered read; holds its value when no read is requested.
   always_ff @(posedge clk) begin
      if (srst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule : combination_replay_mem

// File: rtl/combination.sv
// Go-back-N replay buffer. Words are written in order, sent in order, and kept
// until acknowledged; nak rewinds the send pointer to the oldest unacked word.
module combination
   import combination_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic             oe,
   output logic             full,
   output logic             empty,
   output logic [AW-1:0]    w_addr,
   output logic [AW-1:0]    r_addr,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   input  logic             ack,
   input  logic             nak
);

   localparam ptr_t DEPTH_PTR = ptr_t'(DEPTH);
   localparam ptr_t ONE_PTR   = ptr_t'(1);

   ptr_t wp_q, wp_d;   // next entry to write
   ptr_t rp_q, rp_d;   // next entry to send
   ptr_t ap_q, ap_d;   // oldest unacknowledged entry

   logic do_write;
   logic do_send;
   logic nak_eff;

   assign w_addr = wp_q[AW-1:0];
   assign r_addr = rp_q[AW-1:0];
   assign full   = ((wp_q - ap_q) == DEPTH_PTR);
   assign empty  = (rp_q == wp_q);

   // Next-state pointer logic. ack beats nak; nak suppresses any send;
   // ack captures rp before this cycle's send so the word sent now stays unacked.
   always_comb begin
      nak_eff  = nak && !ack;
      do_write = we && !full;
      do_send  = oe && !empty && !nak_eff;
      wp_d     = wp_q;
      rp_d     = rp_q;
      ap_d     = ap_q;
      if (do_write) begin
         wp_d = wp_q + ONE_PTR;
      end
      if (nak_eff) begin
         rp_d = ap_q;
      end else if (do_send) begin
         rp_d = rp_q + ONE_PTR;
      end
      if (ack) begin
         ap_d = rp_q;
      end
   end

   // Pointer registers; reset discards everything outstanding.
   always_ff @(posedge clk) begin
      if (reset) begin
         wp_q <= '0;
         rp_q <= '0;
         ap_q <= '0;
      end else begin
         wp_q <= wp_d;
         rp_q <= rp_d;
         ap_q <= ap_d;
      end
   end

   combination_replay_mem #(
      .MW  (WIDTH),
      .MD  (DEPTH),
      .MAW (AW)
   ) u_mem (
      .clk     (clk),
      .srst    (reset),
      .we_i    (do_write),
      .waddr_i (w_addr),
      .wdata_i (din),
      .re_i    (do_send),
      .raddr_i (r_addr),
      .rdata_o (dout)
   );

endmodule : combination

// File: tb/tb_combination.sv
// Directed bench for the go-back-N replay buffer.
module tb_combination;
   import combination_pkg::*;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             we = 1'b0;
   logic             oe = 1'b0;
   logic             full;
   logic             empty;
   logic [AW-1:0]    w_addr;
   logic [AW-1:0]    r_addr;
   logic [WIDTH-1:0] din = '0;
   logic [WIDTH-1:0] dout;
   logic             ack = 1'b0;
   logic             nak = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;

   combination dut (
      .clk    (clk),
      .reset  (reset),
      .we     (we),
      .oe     (oe),
      .full   (full),
      .empty  (empty),
      .w_addr (w_addr),
      .r_addr (r_addr),
      .din    (din),
      .dout   (dout),
      .ack    (ack),
      .nak    (nak)
   );

   always #5 clk = ~clk;

   // One clock with the given inputs applied; outputs are sampled 1ns after the edge.
   task automatic step(input logic s_we, input logic s_oe, input logic s_ack,
                       input logic s_nak, input logic [31:0] s_din);
      we  = s_we;
      oe  = s_oe;
      ack = s_ack;
      nak = s_nak;
      din = WIDTH'(s_din);
      @(posedge clk);
      #1;
      we  = 1'b0;
      oe  = 1'b0;
      ack = 1'b0;
      nak = 1'b0;
      $display("txn we=%0b oe=%0b ack=%0b nak=%0b din=%h -> w_addr=%0d r_addr=%0d full=%0b empty=%0b dout=%h",
               s_we, s_oe, s_ack, s_nak, s_din, w_addr, r_addr, full, empty, dout[31:0]);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      reset = 1'b0;
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0b want 1", empty); end
      n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0b want 0", full); end
      n_cmp++; if (w_addr !== 3'd0) begin n_fail++; $display("FAIL reset_w_addr got %0d want 0", w_addr); end
      n_cmp++; if (r_addr !== 3'd0) begin n_fail++; $display("FAIL reset_r_addr got %0d want 0", r_addr); end
      n_cmp++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got %h want 0", dout[31:0]); end
   endtask

   task automatic test_write_send();
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0001);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h1111);
      n_cmp++; if (w_addr !== 3'd2) begin n_fail++; $display("FAIL ws_w_addr got %0d want 2", w_addr); end
      n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL ws_empty got %0b want 0", empty); end
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (dout !== WIDTH'(32'h0001)) begin n_fail++; $display("FAIL ws_dout0 got %h want 00000001", dout[31:0]); end
      n_cmp++; if (r_addr !== 3'd1) begin n_fail++; $display("FAIL ws_r_addr1 got %0d want 1", r_addr); end
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (dout !== WIDTH'(32'h1111)) begin n_fail++; $display("FAIL ws_dout1 got %h want 00001111", dout[31:0]); end
      n_cmp++; if (r_addr !== 3'd2) begin n_fail++; $display("FAIL ws_r_addr2 got %0d want 2", r_addr); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ws_empty_end got %0b want 1", empty); end
   endtask

   // wp=rp=2, ap=0 on entry; ack sets ap=2.
   task automatic test_ack_rewrite();
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h1101);
      n_cmp++; if (w_addr !== 3'd3) begin n_fail++; $display("FAIL ar_w_addr got %0d want 3", w_addr); end
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (dout !== WIDTH'(32'h1101)) begin n_fail++; $display("FAIL ar_dout got %h want 00001101", dout[31:0]); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ar_empty got %0b want 1", empty); end
   endtask

   task automatic test_nak();
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      n_cmp++; if (r_addr !== 3'd2) begin n_fail++; $display("FAIL nak_r_addr got %0d want 2", r_addr); end
      n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL nak_empty got %0b want 0", empty); end
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (dout !== WIDTH'(32'h1101)) begin n_fail++; $display("FAIL nak_dout got %h want 00001101", dout[31:0]); end
      n_cmp++; if (r_addr !== 3'd3) begin n_fail++; $display("FAIL nak_r_addr2 got %0d want 3", r_addr); end
   endtask

   // wp=rp=3, ap=2 on entry; ack frees everything, then 8 writes fill the buffer.
   task automatic test_full();
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      for (int i = 0; i < 8; i++) begin
         n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_early[%0d] got %0b want 0", i, full); end
         step(1'b1, 1'b0, 1'b0, 1'b0, 32'hA0 + 32'(i));
      end
      n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_set got %0b want 1", full); end
      n_cmp++; if (w_addr !== 3'd3) begin n_fail++; $display("FAIL full_w_addr got %0d want 3", w_addr); end
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'hDEAD);
      n_cmp++; if (w_addr !== 3'd3) begin n_fail++; $display("FAIL full_ignored_w_addr got %0d want 3", w_addr); end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
         n_cmp++; if (dout !== WIDTH'(32'hA0 + 32'(i))) begin n_fail++; $display("FAIL full_send[%0d] got %h want %h", i, dout[31:0], 32'hA0 + 32'(i)); end
      end
      n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_before_ack got %0b want 1", full); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_empty got %0b want 1", empty); end
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_after_ack got %0b want 0", full); end
   endtask

   // wp=rp=ap=11: oe while empty must do nothing.
   task automatic test_empty_oe();
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (dout !== WIDTH'(32'hA7)) begin n_fail++; $display("FAIL eoe_dout got %h want 000000a7", dout[31:0]); end
      n_cmp++; if (r_addr !== 3'd3) begin n_fail++; $display("FAIL eoe_r_addr got %0d want 3", r_addr); end
   endtask

   task automatic test_ack_nak();
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h55);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h66);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (dout !== WIDTH'(32'h55)) begin n_fail++; $display("FAIL an_dout got %h want 00000055", dout[31:0]); end
      step(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
      n_cmp++; if (r_addr !== 3'd4) begin n_fail++; $display("FAIL an_r_addr got %0d want 4", r_addr); end
      // ap now equals rp, so a lone nak must not move rp.
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      n_cmp++; if (r_addr !== 3'd4) begin n_fail++; $display("FAIL an_nak_r_addr got %0d want 4", r_addr); end
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (dout !== WIDTH'(32'h66)) begin n_fail++; $display("FAIL an_dout2 got %h want 00000066", dout[31:0]); end
   endtask

   // wp=rp=13, ap=12: ack with a send leaves the sent word unacked.
   task automatic test_ack_with_oe();
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h77);
      step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      n_cmp++; if (dout !== WIDTH'(32'h77)) begin n_fail++; $display("FAIL ao_dout got %h want 00000077", dout[31:0]); end
      step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
      n_cmp++; if (r_addr !== 3'd5) begin n_fail++; $display("FAIL ao_r_addr got %0d want 5", r_addr); end
      n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL ao_empty got %0b want 0", empty); end
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (dout !== WIDTH'(32'h77)) begin n_fail++; $display("FAIL ao_resend got %h want 00000077", dout[31:0]); end
   endtask

   // wp=rp=14, ap=13: nak beats oe, plus pointer wrap past address 7.
   task automatic test_nak_over_oe();
      step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h88);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (dout !== WIDTH'(32'h88)) begin n_fail++; $display("FAIL no_dout got %h want 00000088", dout[31:0]); end
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h99);
      n_cmp++; if (w_addr !== 3'd0) begin n_fail++; $display("FAIL no_w_wrap got %0d want 0", w_addr); end
      step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      n_cmp++; if (r_addr !== 3'd6) begin n_fail++; $display("FAIL no_r_addr got %0d want 6", r_addr); end
      n_cmp++; if (dout !== WIDTH'(32'h88)) begin n_fail++; $display("FAIL no_dout_held got %h want 00000088", dout[31:0]); end
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      n_cmp++; if (dout !== WIDTH'(32'h99)) begin n_fail++; $display("FAIL no_dout_wrap got %h want 00000099", dout[31:0]); end
      n_cmp++; if (r_addr !== 3'd0) begin n_fail++; $display("FAIL no_r_wrap got %0d want 0", r_addr); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL no_empty got %0b want 1", empty); end
   endtask

   task automatic test_reset_mid();
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h1234);
      reset = 1'b1;
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h5678);
      reset = 1'b0;
      n_cmp++; if (w_addr !== 3'd0) begin n_fail++; $display("FAIL rm_w_addr got %0d want 0", w_addr); end
      n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rm_empty got %0b want 1", empty); end
      n_cmp++; if (dout !== '0) begin n_fail++; $display("FAIL rm_dout got %h want 0", dout[31:0]); end
   endtask

   initial begin
      test_reset();
      test_write_send();
      test_ack_rewrite();
      test_nak();
      test_full();
      test_empty_oe();
      test_ack_nak();
      test_ack_with_oe();
      test_nak_over_oe();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_combination
